fetch_unit: RTL and testbench

//  PC register, instruction register (IR) and next-PC logic for the multi-cycle MIPS-lite core.

---
 rtl/mipslite_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_npc.sv | 33 +++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mipslite_pkg.sv
// Shared encodings for the MIPS-lite fetch path: next-PC selects, fetch FSM states, reset PC.
package mipslite_pkg;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BEQ = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: request/address out, ack/data back.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC select for non-fetch PC writes (pc+4, beq, j/jal, jr).
import mipslite_pkg::*;

module npc_calc (
  input  logic [31:0] pc,
  input  logic [25:0] ir,       // instruction bits [25:0]; the opcode field is never needed here
  input  logic [1:0]  NPCop,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic        addr_err
);

  logic [31:0] br_off;

  assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    npc      = pc + 32'd4;
    addr_err = 1'b0;
    case (npc_op_e'(NPCop))
      NPC_PC4: npc = pc + 32'd4;
      NPC_BEQ: npc = zero ? pc + br_off : pc;
      NPC_J:   npc = {pc[31:28], ir[25:0], 2'b00};
      NPC_JR: begin
        npc      = {rs_data[31:2], 2'b00};
        addr_err = |rs_data[1:0];
      end
      default: npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC/IR registers and fetch FSM for the multi-cycle MIPS-lite core; stalls the controller
// while an instruction fetch is outstanding and aborts a fetch that never gets an ack.
import mipslite_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned TW       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWr,
  input  logic              IRWr,
  input  logic [1:0]        NPCop,
  input  logic              zero,
  input  logic [31:0]       rs_data,
  fetch_unit_if.master      imem,
  output logic [31:0]       ir,
  output logic [31:0]       pc,
  output logic [31:0]       pc_link,
  output logic              stall,
  output logic              fetch_err,
  output logic              addr_err
);

  fetch_state_e state;
  logic [TW-1:0] cnt;
  logic [31:0]   npc;
  logic          npc_addr_err;
  logic          idle, waiting, start, last;

  npc_calc u_npc (
    .pc       (pc),
    .ir       (ir[25:0]),
    .NPCop    (NPCop),
    .zero     (zero),
    .rs_data  (rs_data),
    .npc      (npc),
    .addr_err (npc_addr_err)
  );

  assign idle    = (state == ST_IDLE);
  assign waiting = (state == ST_WAIT);
  assign start   = idle & IRWr;
  assign last    = (cnt == TW'(TIMEOUT - 1));
  assign pc_link = pc;

  // Handshake outputs are combinational so a same-cycle ack completes without a stall;
  // gating with rst drops the request the moment reset asserts.
  always_comb begin
    imem.req  = rst & (start | waiting);
    imem.addr = pc;
    stall     = rst & ((start & ~imem.ack) | (waiting & ~imem.ack & ~last));
    fetch_err = rst & waiting & ~imem.ack & last;
    addr_err  = rst & idle & PCWr & ~IRWr & npc_addr_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IRWr) begin
            if (imem.ack) begin
              ir <= imem.rdata;
              pc <= pc + 32'd4;
            end else begin
              cnt   <= '0;
              state <= ST_WAIT;
            end
          end else if (PCWr) begin
            pc <= npc;
          end
        end
        ST_WAIT: begin
          if (imem.ack) begin
            ir    <= imem.rdata;
            pc    <= pc + 32'd4;
            state <= ST_IDLE;
          end else if (last) begin
            ir    <= '0;
            pc    <= pc + 32'd4;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch latencies, timeout, next-PC modes and reset mid-fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWr = 1'b0;
  logic        IRWr = 1'b0;
  logic [1:0]  NPCop = 2'b00;
  logic        zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] ir, pc, pc_link;
  logic        stall, fetch_err, addr_err;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit_if imem_bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .TIMEOUT  (16),
    .TW       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .NPCop     (NPCop),
    .zero      (zero),
    .rs_data   (rs_data),
    .imem      (imem_bus),
    .ir        (ir),
    .pc        (pc),
    .pc_link   (pc_link),
    .stall     (stall),
    .fetch_err (fetch_err),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    #2 rst = 1'b0;
    IRWr = 1'b1;
    #2;
    vectors++; if (pc !== 32'h3000) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
    vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL reset_ir got %h want %h", ir, 32'h0); end
    vectors++; if (pc_link !== 32'h3000) begin miscompares++; $display("FAIL reset_pc_link got %h want %h", pc_link, 32'h3000); end
    vectors++; if (imem_bus.addr !== 32'h3000) begin miscompares++; $display("FAIL reset_addr got %h want %h", imem_bus.addr, 32'h3000); end
    vectors++; if ({imem_bus.req, stall, fetch_err, addr_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags got %b want 0000", {imem_bus.req, stall, fetch_err, addr_err}); end
    IRWr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch_same_cycle();
    IRWr = 1'b1; PCWr = 1'b1; imem_bus.ack = 1'b1; imem_bus.rdata = 32'h3421_0005;
    #1;
    vectors++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h3000) begin
      miscompares++; $display("FAIL fast_req got req=%b addr=%h want req=1 addr=3000", imem_bus.req, imem_bus.addr); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fast_stall got %b want 0", stall); end
    tick();
    IRWr = 1'b0; PCWr = 1'b0; imem_bus.ack = 1'b0;
    #1;
    vectors++; if (ir !== 32'h3421_0005) begin miscompares++; $display("FAIL fast_ir got %h want %h", ir, 32'h3421_0005); end
    vectors++; if (pc !== 32'h3004 || pc_link !== 32'h3004) begin
      miscompares++; $display("FAIL fast_pc got pc=%h link=%h want 3004", pc, pc_link); end
    vectors++; if (stall !== 1'b0 || imem_bus.req !== 1'b0) begin
      miscompares++; $display("FAIL fast_idle got stall=%b req=%b want 0 0", stall, imem_bus.req); end
  endtask

  task automatic test_fetch_late();
    int stalls = 0;
    IRWr = 1'b1; PCWr = 1'b1; imem_bus.rdata = 32'h1000_FFFE;
    for (int c = 0; c < 4; c++) begin
      imem_bus.ack = (c == 3);
      #1;
      if (stall) stalls++;
      vectors++; if (imem_bus.req !== 1'b1) begin miscompares++; $display("FAIL late_req cycle %0d got %b want 1", c, imem_bus.req); end
      if (c < 3) begin
        vectors++; if (ir !== 32'h3421_0005) begin miscompares++; $display("FAIL late_ir_hold cycle %0d got %h want %h", c, ir, 32'h3421_0005); end
      end
      tick();
    end
    IRWr = 1'b0; PCWr = 1'b0; imem_bus.ack = 1'b0;
    #1;
    vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL late_stall_cycles got %0d want 3", stalls); end
    vectors++; if (ir !== 32'h1000_FFFE) begin miscompares++; $display("FAIL late_ir got %h want %h", ir, 32'h1000_FFFE); end
    vectors++; if (pc !== 32'h3008) begin miscompares++; $display("FAIL late_pc got %h want %h", pc, 32'h3008); end
    vectors++; if (imem_bus.req !== 1'b0) begin miscompares++; $display("FAIL late_req_drop got %b want 0", imem_bus.req); end
  endtask

  task automatic test_beq();
    PCWr = 1'b1; NPCop = 2'b01; zero = 1'b0;
    #1;
    vectors++; if (addr_err !== 1'b0 || stall !== 1'b0) begin
      miscompares++; $display("FAIL beq_flags got addr_err=%b stall=%b want 0 0", addr_err, stall); end
    tick();
    vectors++; if (pc !== 32'h3008) begin miscompares++; $display("FAIL beq_not_taken got %h want %h", pc, 32'h3008); end
    zero = 1'b1;
    tick();
    PCWr = 1'b0; zero = 1'b0;
    vectors++; if (pc !== 32'h3000) begin miscompares++; $display("FAIL beq_taken got %h want %h", pc, 32'h3000); end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    int err_at = -1;
    IRWr = 1'b1; PCWr = 1'b1; NPCop = 2'b00; imem_bus.ack = 1'b0;
    for (int c = 0; c < 40 && err_at < 0; c++) begin
      #1;
      if (stall) stalls++;
      if (fetch_err) err_at = c;
      tick();
    end
    IRWr = 1'b0; PCWr = 1'b0;
    #1;
    vectors++; if (err_at !== 16) begin miscompares++; $display("FAIL timeout_err_cycle got %0d want 16", err_at); end
    vectors++; if (stalls !== 16) begin miscompares++; $display("FAIL timeout_stall_cycles got %0d want 16", stalls); end
    vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL timeout_ir got %h want 0", ir); end
    vectors++; if (pc !== 32'h3004) begin miscompares++; $display("FAIL timeout_pc got %h want %h", pc, 32'h3004); end
    vectors++; if (fetch_err !== 1'b0 || stall !== 1'b0 || imem_bus.req !== 1'b0) begin
      miscompares++; $display("FAIL timeout_after got err=%b stall=%b req=%b want 000", fetch_err, stall, imem_bus.req); end
  endtask

  task automatic test_jr_and_j();
    PCWr = 1'b1; NPCop = 2'b11; rs_data = 32'h0000_3012;
    #1;
    vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("FAIL jr_addr_err got %b want 1", addr_err); end
    tick();
    PCWr = 1'b0;
    #1;
    vectors++; if (pc !== 32'h3010) begin miscompares++; $display("FAIL jr_pc got %h want %h", pc, 32'h3010); end
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL jr_err_pulse got %b want 0", addr_err); end
    IRWr = 1'b1; PCWr = 1'b1; imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0800_0C01;
    tick();
    IRWr = 1'b0; imem_bus.ack = 1'b0;
    vectors++; if (pc !== 32'h3014 || ir !== 32'h0800_0C01) begin
      miscompares++; $display("FAIL j_fetch got pc=%h ir=%h want 3014 08000c01", pc, ir); end
    NPCop = 2'b10;
    tick();
    vectors++; if (pc !== 32'h3004) begin miscompares++; $display("FAIL j_pc got %h want %h", pc, 32'h3004); end
    NPCop = 2'b00;
    tick();
    PCWr = 1'b0;
    vectors++; if (pc !== 32'h3008) begin miscompares++; $display("FAIL pc4 got %h want %h", pc, 32'h3008); end
  endtask

  task automatic test_reset_in_wait();
    IRWr = 1'b1; PCWr = 1'b1; imem_bus.ack = 1'b0;
    tick();
    tick();
    #2;
    vectors++; if (imem_bus.req !== 1'b1 || stall !== 1'b1) begin
      miscompares++; $display("FAIL rstwait_pre got req=%b stall=%b want 1 1", imem_bus.req, stall); end
    rst = 1'b0;
    #1;
    vectors++; if (imem_bus.req !== 1'b0 || stall !== 1'b0) begin
      miscompares++; $display("FAIL rstwait_req got req=%b stall=%b want 0 0", imem_bus.req, stall); end
    vectors++; if (pc !== 32'h3000 || ir !== 32'h0) begin
      miscompares++; $display("FAIL rstwait_regs got pc=%h ir=%h want 3000 0", pc, ir); end
    IRWr = 1'b0; PCWr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
    tick();
    imem_bus.ack = 1'b0;
    vectors++; if (ir !== 32'h0 || pc !== 32'h3000) begin
      miscompares++; $display("FAIL rstwait_late_ack got pc=%h ir=%h want 3000 0", pc, ir); end
  endtask

  initial begin
    test_reset();
    test_fetch_same_cycle();
    test_fetch_late();
    test_beq();
    test_timeout();
    test_jr_and_j();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
